// File: rtl/tb_mmio_pkg.sv
// rtl/tb_mmio_pkg.sv - register offsets, PASS magic value and address-decode helper for tb_mmio_ctrl
package tb_mmio_pkg;

    localparam logic [31:0] OFF_PASS   = 32'h0;
    localparam logic [31:0] OFF_FAIL   = 32'h4;
    localparam logic [31:0] OFF_EXIT   = 32'h8;
    localparam logic [31:0] OFF_CYCLE  = 32'hC;
    localparam logic [31:0] PASS_MAGIC = 32'd123456789;

    typedef enum logic [2:0] {
        DEC_NONE,
        DEC_PRINT,
        DEC_PASS,
        DEC_FAIL,
        DEC_EXIT,
        DEC_CYCLE
    } dec_e;

    function automatic dec_e decode(input logic [31:0] addr,
                                    input logic [31:0] print_addr,
                                    input logic [31:0] ctrl_base);
        dec_e d;
        d = DEC_NONE;
        if (addr == print_addr)                  d = DEC_PRINT;
        else if (addr == ctrl_base + OFF_PASS)   d = DEC_PASS;
        else if (addr == ctrl_base + OFF_FAIL)   d = DEC_FAIL;
        else if (addr == ctrl_base + OFF_EXIT)   d = DEC_EXIT;
        else if (addr == ctrl_base + OFF_CYCLE)  d = DEC_CYCLE;
        return d;
    endfunction

endpackage

// File: rtl/tb_mmio_fifo.sv
// rtl/tb_mmio_fifo.sv - 8-bit stdout character FIFO; a pop frees a slot for a push in the same cycle
module tb_mmio_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int             AW        = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tb_mmio_ctrl.sv
// rtl/tb_mmio_ctrl.sv - simulation MMIO block: stdout FIFO, PASS/FAIL/EXIT status, CYCLE counter
// Optional CYCLE counter enabled by macro TB_MMIO_CYCLE_CNT_EN.
module tb_mmio_ctrl
    import tb_mmio_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] PRINT_ADDR = 32'h1000_0000,
    parameter logic [31:0] CTRL_BASE  = 32'h2000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        tx_valid_o,
    output logic [7:0]  tx_data_o,
    input  logic        tx_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    dec_e                          dec;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          print_stall;
    logic                          wr;
    logic                          fifo_push;
    logic                          drained;
    logic [31:0]                   cycle_val;
    logic [31:0]                   rdata_d;
    logic                          pass_hit, fail_hit, exit_hit;
    logic                          pass_pend, fail_pend, exit_seen, exit_pend;
    logic [31:0]                   exit_hold;
    logic                          unused_be;

    assign unused_be = ^data_be_i[3:1];

    assign dec         = decode(data_addr_i, PRINT_ADDR, CTRL_BASE);
    assign print_stall = data_we_i && (dec == DEC_PRINT) && fifo_full && !tx_ready_i;
    assign data_gnt_o  = !rst_i && data_req_i && (dec != DEC_NONE) && !print_stall;
    assign wr          = data_gnt_o && data_we_i;
    assign fifo_push   = wr && (dec == DEC_PRINT) && data_be_i[0];
    assign tx_valid_o  = !fifo_empty;
    assign drained     = (fifo_count == '0);

    tb_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (fifo_push),
        .push_data (data_wdata_i[7:0]),
        .pop       (tx_valid_o && tx_ready_i),
        .head      (tx_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef TB_MMIO_CYCLE_CNT_EN
    logic [31:0] cycle_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
    end
    assign cycle_val = cycle_q;
`else
    assign cycle_val = 32'h0;
`endif

    assign rdata_d = (data_gnt_o && !data_we_i && dec == DEC_CYCLE) ? cycle_val : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= '0;
        end else begin
            data_rvalid_o <= data_gnt_o;
            data_rdata_o  <= rdata_d;
        end
    end

    // Status writes are accepted at once but only become visible once stdout has drained.
    assign pass_hit  = wr && (dec == DEC_PASS) && (data_wdata_i == PASS_MAGIC);
    assign fail_hit  = wr && (dec == DEC_FAIL);
    assign exit_hit  = wr && (dec == DEC_EXIT) && !exit_seen;
    assign exit_pend = exit_seen && !exit_valid_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pass_pend      <= 1'b0;
            fail_pend      <= 1'b0;
            exit_seen      <= 1'b0;
            exit_hold      <= '0;
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else begin
            if (pass_hit || pass_pend) begin
                if (drained) begin
                    tests_passed_o <= 1'b1;
                    pass_pend      <= 1'b0;
                end else begin
                    pass_pend      <= 1'b1;
                end
            end
            if (fail_hit || fail_pend) begin
                if (drained) begin
                    tests_failed_o <= 1'b1;
                    fail_pend      <= 1'b0;
                end else begin
                    fail_pend      <= 1'b1;
                end
            end
            if (exit_hit) begin
                exit_seen <= 1'b1;
                exit_hold <= data_wdata_i;
            end
            if ((exit_hit || exit_pend) && drained) begin
                exit_valid_o <= 1'b1;
                exit_value_o <= exit_hit ? data_wdata_i : exit_hold;
            end
        end
    end

endmodule

// File: doc/tb_mmio_ctrl.md
TB_MMIO_CTRL -- requirements
Module: tb_mmio_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, stdout FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter PRINT_ADDR, default 32'h1000_0000, stdout character register.
REQ-003 SHALL have parameter CTRL_BASE, default 32'h2000_0000: PASS at +0x0, FAIL at +0x4, EXIT at +0x8, CYCLE at +0xC.
REQ-004 SHALL have port clk_i  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports data_req_i in 1, data_addr_i in 32, data_we_i in 1, data_be_i in 4, data_wdata_i in 32: core data-bus request.
REQ-007 SHALL have ports data_gnt_o out 1, data_rvalid_o out 1, data_rdata_o out 32: grant, response valid, read data.
REQ-008 SHALL have ports tx_valid_o out 1, tx_data_o out 8, tx_ready_i in 1: stdout character stream.
REQ-009 SHALL have ports tests_passed_o, tests_failed_o, exit_valid_o (out 1 each) and exit_value_o (out 32).

Function
REQ-010 SHALL accept a request only when data_req_i and data_addr_i decodes to PRINT_ADDR or a CTRL register; other addresses are never granted.
REQ-011 SHALL assert data_gnt_o combinationally in the request cycle, except a PRINT write when the FIFO is full (gnt low until space exists).
REQ-012 SHALL assert data_rvalid_o exactly one cycle after each grant, for reads and writes, with back-to-back grants giving back-to-back rvalid.
REQ-013 SHALL return CYCLE value on rdata for reads of CTRL+0xC; all other reads, and all write responses, SHALL return 32'h0.
REQ-014 SHALL push data_wdata_i[7:0] into the FIFO on a granted PRINT write with data_be_i[0]=1; be[0]=0 SHALL be granted and discarded.
REQ-015 SHALL drive tx_valid_o = FIFO not empty, tx_data_o = FIFO head; pop on tx_valid_o & tx_ready_i.
REQ-016 SHALL support simultaneous push and pop when full: pop frees the slot in the same cycle, so gnt is high and count stays FIFO_DEPTH.
REQ-017 SHALL use wrapping read/write pointers of $clog2(FIFO_DEPTH) bits plus a count of $clog2(FIFO_DEPTH)+1 bits.
REQ-018 SHALL set tests_passed_o (sticky) one cycle after a granted write of 32'd123456789 to PASS; other values ignored.
REQ-019 SHALL set tests_failed_o (sticky) one cycle after any granted write to FAIL.
REQ-020 SHALL set exit_valid_o (sticky) and latch exit_value_o = data_wdata_i one cycle after the first granted EXIT write; later EXIT writes ignored.
REQ-021 SHALL hold status outputs until FIFO empty: a status write is granted but its flag is deferred (pending bit) until count==0, so tb_top does not finish before stdout drains.
REQ-022 SHALL increment the 32-bit CYCLE counter every cycle out of reset, wrapping 32'hFFFF_FFFF -> 0.

Reset
REQ-023 SHALL, while rst_i is high, clear FIFO pointers/count, pending bits, all status flags, exit_value_o=0, CYCLE=0, data_rvalid_o=0, tx_valid_o=0.
REQ-024 SHALL, on rst_i mid-transaction, drop any outstanding rvalid and discard FIFO contents; data_gnt_o SHALL be 0 during reset.

Configuration
REQ-025 SHALL gate the CYCLE counter with macro TB_MMIO_CYCLE_CNT_EN: defined -> REQ-022 and REQ-013 as stated; undefined -> no counter flops, CYCLE reads granted and return 32'h0.

Structure
REQ-026 SHALL place register offsets, PASS magic value 123456789 and an address-decode enum (DEC_NONE, DEC_PRINT, DEC_PASS, DEC_FAIL, DEC_EXIT, DEC_CYCLE) in package tb_mmio_pkg.
REQ-027 SHALL implement the stdout FIFO as sub-module tb_mmio_fifo (push/pop/full/empty/count, parameter DEPTH, width 8).

Verification
REQ-028 SHALL test: write 'H','i' to PRINT with tx_ready_i=1 -> tx_data_o 8'h48 then 8'h69 on consecutive cycles, rvalid one cycle after each gnt.
REQ-029 SHALL test: tx_ready_i=0, 9 PRINT writes with FIFO_DEPTH=8 -> 8 granted, 9th gnt low until tx_ready_i=1 for one cycle, then granted.
REQ-030 SHALL test: 3 chars queued, tx_ready_i=0, write 123456789 to PASS -> tests_passed_o stays 0; raise tx_ready_i -> tests_passed_o rises one cycle after FIFO empty.
REQ-031 SHALL test: EXIT writes 32'd5 then 32'd0 with empty FIFO -> exit_valid_o=1, exit_value_o=5 held.
REQ-032 SHALL test: read CYCLE 10 cycles after reset release -> 32'd10 with macro, 32'h0 without; rst_i pulse mid-stream -> FIFO empty, flags 0 next cycle.
